avr_fetch_queue: RTL and testbench

AVR_FETCH_QUEUE -- requirements
Module: avr_fetch_queue

---
 rtl/avr_fetch_queue.sv | 109 ++++++++++
 tb/tb_avr_fetch_queue.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/avr_fetch_queue.sv
// AVR instruction prefetch queue.
// Streams program words from an in-order, variable-latency program memory into a
// small FIFO and presents the head instruction, pairing the two words of the
// 32-bit encodings (LDS/STS, JMP, CALL). A flush redirects the stream and drops
// every response still in flight from before the redirect.
module avr_fetch_queue #(
  parameter int PADDR_W = 16,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               RST,
  output logic               p_req,
  output logic [PADDR_W-1:0] p_addr,
  input  logic [15:0]        p_rdata,
  input  logic               p_rvalid,
  output logic [15:0]        instr,
  output logic [15:0]        instr2,
  output logic [PADDR_W-1:0] instr_pc,
  output logic               instr_long,
  output logic               instr_valid,
  input  logic               instr_take,
  input  logic               flush,
  input  logic [PADDR_W-1:0] flush_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [15:0]   mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  logic [15:0]   head_word;
  logic [15:0]   next_word;
  logic          head_long;
  logic          pop;
  logic          push;
  logic [CW-1:0] pop_amt;
  logic [CW:0]   demand;

  assign head_word = mem[rd_ptr];
  assign next_word = mem[rd_ptr + PW'(1)];

  // Storage contents are meaningless while empty, so the decode is qualified by count.
  assign head_long = (count != '0) &&
                     (((head_word & 16'hFC0F) == 16'h9000) ||
                      ((head_word & 16'hFE0C) == 16'h940C));

  assign instr_valid = (count >= CW'(1)) && (!head_long || (count >= CW'(2)));
  assign instr_long  = head_long;
  assign instr       = instr_valid ? head_word : 16'h0000;
  assign instr2      = (instr_valid && head_long) ? next_word : 16'h0000;

  assign pop     = instr_take && instr_valid && !flush;
  assign pop_amt = head_long ? CW'(2) : CW'(1);
  assign push    = p_rvalid && !flush && (discard == '0);

  // Every word already queued or still in flight has a reserved slot, so a push
  // can never find the queue full. RST gates the request so it stays low while
  // reset is held, independent of the clock.
  assign demand = {1'b0, count} + {1'b0, outstanding} + {{CW{1'b0}}, pop};
  assign p_req  = RST && !flush && (demand < (CW+1)'(DEPTH));

  // Word storage: written at the tail on accepted responses.
  // NOTE: the storage array has no reset; count alone decides which entries are
  // live, so clearing the array would only add reset fan-out.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= p_rdata;
  end

  // Queue pointers, fetch/consume addresses and the in-flight/discard counters.
  // NOTE: all state here uses non-blocking assignments so every update reads the
  // pre-edge values, which the net count and counter arithmetic rely on.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
      p_addr      <= '0;
      instr_pc    <= '0;
    end else if (flush) begin
      // A response arriving in the flush cycle is dropped here; everything
      // still outstanding after it is marked for discard.
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      p_addr      <= flush_pc;
      instr_pc    <= flush_pc;
      outstanding <= outstanding - CW'(p_rvalid);
      discard     <= outstanding - CW'(p_rvalid);
    end else begin
      if (p_req) p_addr <= p_addr + PADDR_W'(1);
      if (push)  wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + pop_amt[PW-1:0];
        instr_pc <= instr_pc + PADDR_W'(pop_amt);
      end
      count       <= count + CW'(push) - (pop ? pop_amt : CW'(0));
      outstanding <= outstanding + CW'(p_req) - CW'(p_rvalid);
      if (p_rvalid && (discard != '0)) discard <= discard - CW'(1);
    end
  end

endmodule

// File: tb/tb_avr_fetch_queue.sv
// Self-checking bench for avr_fetch_queue.
// A program memory with configurable in-order latency answers the DUT's requests.
// The reference model tracks the fetch stream as a list of queued addresses and a
// list of in-flight requests each tagged keep/drop; expected outputs are derived
// from those lists every cycle. A second instance with a 4-bit address width
// shares all inputs to exercise address wrap-around.
module tb_avr_fetch_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        p_req;
  logic [15:0] p_addr;
  logic [15:0] p_rdata = '0;
  logic        p_rvalid = 1'b0;
  logic [15:0] instr;
  logic [15:0] instr2;
  logic [15:0] instr_pc;
  logic        instr_long;
  logic        instr_valid;
  logic        instr_take = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;

  logic        n_req;
  logic [3:0]  n_addr;
  logic [15:0] n_instr;
  logic [15:0] n_instr2;
  logic [3:0]  n_pc;
  logic        n_long;
  logic        n_valid;

  always #5 CLK = ~CLK;

  avr_fetch_queue #(.PADDR_W(16), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .p_req(p_req), .p_addr(p_addr), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .instr(instr), .instr2(instr2), .instr_pc(instr_pc), .instr_long(instr_long),
    .instr_valid(instr_valid), .instr_take(instr_take),
    .flush(flush), .flush_pc(flush_pc)
  );

  avr_fetch_queue #(.PADDR_W(4), .DEPTH(DEPTH)) dut4 (
    .CLK(CLK), .RST(RST),
    .p_req(n_req), .p_addr(n_addr), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .instr(n_instr), .instr2(n_instr2), .instr_pc(n_pc), .instr_long(n_long),
    .instr_valid(n_valid), .instr_take(instr_take),
    .flush(flush), .flush_pc(flush_pc[3:0])
  );

  typedef struct { logic [15:0] addr; bit drop; } inflight_t;
  typedef struct { int due; logic [15:0] data; } resp_t;

  logic [15:0] mem [0:65535];
  logic [15:0] q[$];
  inflight_t   infl[$];
  resp_t       pend[$];
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  int          cyc;
  int          last_due;
  int          lat_lo = 1;
  int          lat_hi = 1;

  logic        e_req, e_valid, e_long, e_pop;
  logic [15:0] e_instr, e_instr2;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic bit is_long(logic [15:0] w);
    return ((w & 16'hFC0F) == 16'h9000) || ((w & 16'hFE0C) == 16'h940C);
  endfunction

  function automatic logic [66:0] dut_vec();
    return {p_req, instr_valid, instr_long, instr, instr2, instr_pc, p_addr};
  endfunction
  function automatic logic [66:0] exp_vec();
    return {e_req, e_valid, e_long, e_instr, e_instr2, m_pc, m_addr};
  endfunction
  function automatic logic [42:0] dut4_vec();
    return {n_req, n_valid, n_long, n_instr, n_instr2, n_pc, n_addr};
  endfunction
  function automatic logic [42:0] exp4_vec();
    return {e_req, e_valid, e_long, e_instr, e_instr2, m_pc[3:0], m_addr[3:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    infl.delete();
    pend.delete();
    m_pc     = '0;
    m_addr   = '0;
    cyc      = 0;
    last_due = 0;
    p_rvalid = 1'b0;
  endtask

  task automatic do_reset();
    RST        = 1'b0;
    instr_take = 1'b0;
    flush      = 1'b0;
    flush_pc   = '0;
    model_reset();
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  // Called at a falling edge: present the memory response and CPU inputs for this
  // cycle, then derive the expected outputs from the model lists.
  task automatic drive(input bit take, input bit fl, input logic [15:0] fpc);
    p_rvalid   = (pend.size() != 0) && (pend[0].due == cyc);
    p_rdata    = p_rvalid ? pend[0].data : 16'($urandom);
    instr_take = take;
    flush      = fl;
    flush_pc   = fpc;
    #1;
    e_long   = (q.size() != 0) && is_long(mem[q[0]]);
    e_valid  = (q.size() >= 1) && (!e_long || q.size() >= 2);
    e_instr  = e_valid ? mem[q[0]] : 16'h0000;
    e_instr2 = (e_valid && e_long) ? mem[q[1]] : 16'h0000;
    e_pop    = take && e_valid && !fl;
    e_req    = !fl && ((q.size() + infl.size() + int'(e_pop)) < DEPTH);
  endtask

  // Clock edge: the memory accepts the DUT's request, the model applies the cycle.
  task automatic advance();
    bit          req;
    logic [15:0] addr;
    int          due;
    inflight_t   e;
    req  = p_req;
    addr = p_addr;
    @(posedge CLK);
    if (p_rvalid) void'(pend.pop_front());
    if (req) begin
      due = cyc + $urandom_range(lat_hi, lat_lo);
      if (due <= last_due) due = last_due + 1;
      pend.push_back('{due, mem[addr]});
      last_due = due;
    end
    if (flush) begin
      foreach (infl[i]) infl[i].drop = 1'b1;
      if (p_rvalid && infl.size() != 0) void'(infl.pop_front());
      q.delete();
      m_pc   = flush_pc;
      m_addr = flush_pc;
    end else begin
      if (e_pop) begin
        repeat (e_long ? 2 : 1) void'(q.pop_front());
        m_pc = m_pc + 16'(e_long ? 2 : 1);
      end
      if (p_rvalid && infl.size() != 0) begin
        e = infl.pop_front();
        if (!e.drop) q.push_back(e.addr);
      end
      if (e_req) begin
        infl.push_back('{m_addr, 1'b0});
        m_addr = m_addr + 16'd1;
      end
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic test_reset();
    RST        = 1'b0;
    instr_take = 1'b1;
    flush_pc   = 16'h1234;
    model_reset();
    @(negedge CLK);
    #1;
    n_checks++;
    if (dut_vec() !== 67'd0)
      $display("FAIL reset_outputs: got %h expected 0", dut_vec());
    else n_pass++;
    n_checks++;
    if (dut4_vec() !== 43'd0)
      $display("FAIL reset_outputs_w4: got %h expected 0", dut4_vec());
    else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL basic cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if (instr_valid !== 1'b0)
          $display("FAIL basic_early_valid: got %b expected 0", instr_valid);
        else n_pass++;
      end
      if (i == 2) begin
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'hE0A4, 16'h0000})
          $display("FAIL basic_first: got %h expected %h",
                   {instr_valid, instr, instr_pc}, {1'b1, 16'hE0A4, 16'h0000});
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if ({instr_valid, instr, instr_pc} !== {1'b1, 16'h50A1, 16'h0001})
          $display("FAIL basic_second: got %h expected %h",
                   {instr_valid, instr, instr_pc}, {1'b1, 16'h50A1, 16'h0001});
        else n_pass++;
      end
      advance();
    end
  endtask

  task automatic test_long();
    bit took = 1'b0;
    lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL long cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (took) begin
        n_checks++;
        if (instr_pc !== 16'd4)
          $display("FAIL long_pc_advance: got %h expected 0004", instr_pc);
        else n_pass++;
        took = 1'b0;
      end
      if (q.size() == 1 && q[0] == 16'd2) begin
        n_checks++;
        if ({instr_valid, instr} !== {1'b0, 16'h0000})
          $display("FAIL long_partial: got %h expected 00000", {instr_valid, instr});
        else n_pass++;
      end
      if (e_valid && q[0] == 16'd2) begin
        n_checks++;
        if ({instr_long, instr, instr2} !== {1'b1, 16'h940C, 16'h0010})
          $display("FAIL long_pair: got %h expected %h",
                   {instr_long, instr, instr2}, {1'b1, 16'h940C, 16'h0010});
        else n_pass++;
        took = 1'b1;
      end
      advance();
    end
  endtask

  task automatic test_fill();
    int nreq = 0;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      if (p_req) nreq++;
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL fill cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      advance();
    end
    n_checks++;
    if (nreq != 4) $display("FAIL fill_request_count: got %0d expected 4", nreq);
    else n_pass++;
    drive(1'b0, 1'b0, 16'h0);
    n_checks++;
    if ({p_req, instr_valid, instr_pc, instr} !== {1'b0, 1'b1, 16'h0000, mem[0]})
      $display("FAIL fill_full_state: got %h expected %h",
               {p_req, instr_valid, instr_pc, instr}, {1'b0, 1'b1, 16'h0000, mem[0]});
    else n_pass++;
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL fill_drain cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_flush();
    bit seen = 1'b0;
    lat_lo = 3; lat_hi = 3;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 16'h0);
      advance();
    end
    drive(1'b1, 1'b1, 16'h0100);
    n_checks++;
    if (dut_vec() !== exp_vec())
      $display("FAIL flush_cycle: got %h expected %h", dut_vec(), exp_vec());
    else n_pass++;
    advance();
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 1'b0, 16'h0);
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL flush_after cycle %0d: got %h expected %h", i, dut_vec(), exp_vec());
      else n_pass++;
      if (e_valid && !seen) begin
        seen = 1'b1;
        n_checks++;
        if ({instr_pc, instr} !== {16'h0100, mem[16'h0100]})
          $display("FAIL flush_first: got %h expected %h",
                   {instr_pc, instr}, {16'h0100, mem[16'h0100]});
        else n_pass++;
      end
      advance();
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL flush_first: no valid instruction within 15 cycles");
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want16 [4];
    logic [3:0]  want4  [4];
    logic [15:0] start  [2];
    int k;
    start[0] = 16'h000E;
    start[1] = 16'hFFFE;
    lat_lo = 1; lat_hi = 2;
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int j = 0; j < 4; j++) begin
        want16[j] = start[s] + 16'(j);
        want4[j]  = 4'(start[s] + 16'(j));
      end
      k = 0;
      drive(1'b0, 1'b1, start[s]);
      advance();
      for (int i = 0; i < 16; i++) begin
        drive(1'b1, 1'b0, 16'h0);
        n_checks++;
        if (dut_vec() !== exp_vec() || dut4_vec() !== exp4_vec())
          $display("FAIL wrap cycle %0d: got %h/%h expected %h/%h",
                   i, dut_vec(), dut4_vec(), exp_vec(), exp4_vec());
        else n_pass++;
        if (p_req && k < 4) begin
          n_checks++;
          if ({p_addr, n_addr} !== {want16[k], want4[k]})
            $display("FAIL wrap_addr %0d: got %h expected %h",
                     k, {p_addr, n_addr}, {want16[k], want4[k]});
          else n_pass++;
          k++;
        end
        advance();
      end
    end
  endtask

  task automatic test_reset_midstream();
    int i = 0;
    lat_lo = 1; lat_hi = 1;
    do_reset();
    while (q.size() < 2 && i < 10) begin
      drive(1'b0, 1'b0, 16'h0);
      advance();
      i++;
    end
    n_checks++;
    if (q.size() < 2) $display("FAIL midstream_fill: queue never reached 2 words");
    else n_pass++;
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if ({p_req, instr_valid, instr, instr_pc, p_addr} !== 50'd0)
      $display("FAIL midstream_reset: got %h expected 0",
               {p_req, instr_valid, instr, instr_pc, p_addr});
    else n_pass++;
    model_reset();
    @(negedge CLK);
    RST = 1'b1;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b0, 16'h0);
      if (j == 0) begin
        n_checks++;
        if ({p_req, p_addr} !== {1'b1, 16'h0000})
          $display("FAIL midstream_restart: got %h expected 10000", {p_req, p_addr});
        else n_pass++;
      end
      n_checks++;
      if (dut_vec() !== exp_vec())
        $display("FAIL midstream cycle %0d: got %h expected %h", j, dut_vec(), exp_vec());
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_random();
    bit          take;
    bit          fl;
    logic [15:0] fpc;
    lat_lo = 1; lat_hi = 4;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      take = ($urandom_range(9, 0) < 7);
      fl   = ($urandom_range(19, 0) == 0);
      fpc  = 16'($urandom);
      drive(take, fl, fpc);
      n_checks++;
      if (dut_vec() !== exp_vec() || dut4_vec() !== exp4_vec())
        $display("FAIL random cycle %0d: got %h/%h expected %h/%h",
                 i, dut_vec(), dut4_vec(), exp_vec(), exp4_vec());
      else n_pass++;
      advance();
    end
  endtask

  initial begin
    int unsigned r;
    for (int a = 0; a < 65536; a++) begin
      r = $urandom_range(7, 0);
      if (r == 0)      mem[a] = 16'h940C | (16'($urandom) & 16'h01F3);
      else if (r == 1) mem[a] = 16'h9000 | (16'($urandom) & 16'h03F0);
      else             mem[a] = 16'($urandom);
    end
    mem[0]       = 16'hE0A4;
    mem[1]       = 16'h50A1;
    mem[2]       = 16'h940C;
    mem[3]       = 16'h0010;
    mem[16'h100] = 16'hE5A5;

    test_reset();
    test_basic();
    test_long();
    test_fill();
    test_flush();
    test_wrap();
    test_reset_midstream();
    test_random();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
